// File: rtl/leaky_relu_arbiter_pkg.sv
// Shared types and helpers for the leaky-ReLU arbiter: FSM states, default widths
// and the round-robin next-grant search.
package lrelu_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_SHIFT = 3;
    localparam int MAX_REQ   = 32;

    // First set bit of valid searching upward from ptr+1 (mod n); returns ptr when none is set.
    // Walking from the farthest candidate to the nearest lets the nearest one win.
    function automatic int rr_next_grant(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        rr_next_grant = ptr;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (valid[idx[4:0]]) begin
                    rr_next_grant = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/leaky_relu_arbiter_if.sv
// Requester-side and result-side handshake bundle of the leaky-ReLU arbiter.
interface leaky_relu_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int TW    = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [TW-1:0]       out_tag;
    logic                out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/leaky_relu_arbiter_core.sv
// Combinational leaky ReLU: passes non-negative inputs, scales negatives by 2^-SHIFT.
module leaky_relu_core #(
    parameter int DW    = 8,
    parameter int SHIFT = 3
) (
    input  logic signed [DW-1:0] x_i,
    output logic signed [DW-1:0] y_o
);

    // Arithmetic shift floors toward -inf and can only shrink magnitude, so no saturation.
    function automatic logic signed [DW-1:0] lrelu(input logic signed [DW-1:0] x);
        lrelu = x[DW-1] ? (x >>> SHIFT) : x;
    endfunction

    assign y_o = lrelu(x_i);

endmodule

// File: rtl/leaky_relu_arbiter.sv
// Round-robin arbiter sharing one leaky-ReLU stage among N_REQ requesters.
// Optional per-requester accept counters are built when LRELU_ARB_STATS_EN is defined.
module leaky_relu_arbiter
    import lrelu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DEF_DW,
    parameter int SHIFT = DEF_SHIFT,
    parameter int TW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    leaky_relu_arbiter_if.slave  bus,
    output logic                 busy
`ifdef LRELU_ARB_STATS_EN
    ,
    output logic [N_REQ*8-1:0]   stat_cnt
`endif
);

    state_t               state_q;
    logic [TW-1:0]        rr_q;
    logic [TW-1:0]        tag_q;
    logic [TW-1:0]        out_tag_q;
    logic [TW-1:0]        grant;
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] f_x;
    logic signed [DW-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 out_free;
    logic                 accept;
    logic [MAX_REQ-1:0]   valid_ext;
    logic [N_REQ-1:0]     req_ready_d;

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = bus.req_valid;
    end

    assign grant    = TW'(rr_next_grant(valid_ext, int'(rr_q), N_REQ));
    // The output slot is free if empty or draining on this very edge.
    assign out_free = !out_valid_q || bus.out_ready;
    assign accept   = !rst && (state_q == IDLE) && (|bus.req_valid) && out_free;

    always_comb begin
        req_ready_d = '0;
        if (accept) begin
            req_ready_d[grant] = 1'b1;
        end
    end

    leaky_relu_core #(.DW(DW), .SHIFT(SHIFT)) u_core (
        .x_i (x_q),
        .y_o (f_x)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= TW'(N_REQ - 1);
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        x_q     <= $signed(bus.req_data[int'(grant)*DW +: DW]);
                        tag_q   <= grant;
                        rr_q    <= grant;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= f_x;
                    out_tag_q   <= tag_q;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign busy          = (state_q == COMPUTE) || out_valid_q;

`ifdef LRELU_ARB_STATS_EN
    logic [7:0] cnt_q [N_REQ];

    // Counters stick at 255 until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (accept && (cnt_q[grant] != 8'hFF)) begin
            cnt_q[grant] <= cnt_q[grant] + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stat_cnt[i*8 +: 8] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_leaky_relu_arbiter.sv
// Bench for leaky_relu_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_leaky_relu_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int SHIFT = 3;
    localparam int TW    = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef LRELU_ARB_STATS_EN
    logic [N_REQ*8-1:0] stat_cnt;
`endif

    always #5 clk = ~clk;

    leaky_relu_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .TW(TW)) bus ();

    leaky_relu_arbiter #(.N_REQ(N_REQ), .DW(DW), .SHIFT(SHIFT), .TW(TW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef LRELU_ARB_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_comp = 0;
    bit m_ov   = 0;
    int m_x    = 0;
    int m_tag  = 0;
    int m_od   = 0;
    int m_ot   = 0;
    int m_last = N_REQ - 1;
    int m_cnt [N_REQ];
    bit model_on = 0;

    function automatic int fx(input int x);
        int q;
        if (x >= 0) return x;
        q = x / (1 << SHIFT);
        if (q * (1 << SHIFT) != x) q = q - 1;
        return q;
    endfunction

    function automatic int pick(input logic [N_REQ-1:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ] === 1'b1) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int sdata(input int i);
        logic [DW-1:0] b;
        b = bus.req_data[i*DW +: DW];
        return int'($signed(b));
    endfunction

    always @(negedge clk) begin
        int g;
        bit free;
        bit acc;
        logic [N_REQ-1:0] er;
        free = !m_ov || (bus.out_ready === 1'b1);
        g    = pick(bus.req_valid, m_last);
        acc  = (rst === 1'b0) && !m_comp && free && (g >= 0);
        er   = '0;
        if (acc) er[g] = 1'b1;
        if (model_on) begin
            chk("req_ready", 64'(bus.req_ready), 64'(er));
            chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
            if (m_ov) begin
                chk("out_data", 64'(bus.out_data), 64'(m_od & 255));
                chk("out_tag", 64'(bus.out_tag), 64'(m_ot));
            end
            chk("busy", 64'(busy), 64'(m_comp || m_ov));
`ifdef LRELU_ARB_STATS_EN
            for (int i = 0; i < N_REQ; i++) chk("stat_cnt", 64'(stat_cnt[i*8 +: 8]), 64'(m_cnt[i]));
`endif
        end
        if (rst === 1'b1) begin
            m_comp = 0; m_ov = 0; m_od = 0; m_ot = 0; m_last = N_REQ - 1;
            for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        end else begin
            if (m_comp) begin
                m_ov = 1; m_od = fx(m_x); m_ot = m_tag; m_comp = 0;
            end else if (m_ov && bus.out_ready === 1'b1) begin
                m_ov = 0;
            end
            if (acc) begin
                m_comp = 1; m_x = sdata(g); m_tag = g; m_last = g;
                if (m_cnt[g] < 255) m_cnt[g]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] nin  [4] = '{8'h80, 8'hFF, 8'hF9, 8'hF7};
    logic [7:0] nexp [4] = '{8'hF0, 8'hFF, 8'hFF, 8'hFE};

    initial begin
        int tags [6];
        int when [6];
        int n;
        int hold_d;
        int hold_t;
        bit seen;

        for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;

        // Reset held three cycles with every requester asking.
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef LRELU_ARB_STATS_EN
        chk("rst_stat_cnt", 64'(stat_cnt), 64'd0);
`endif
        model_on = 1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", 64'(bus.req_ready), 64'b0001);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();

        // Positive value passes straight through.
        bus.req_valid = 4'b0010;
        bus.req_data[1*DW +: DW] = 8'h50;
        @(negedge clk);
        chk("pos_req_ready", 64'(bus.req_ready), 64'b0010);
        cyc();
        bus.req_valid = '0;
        cyc();
        @(negedge clk);
        chk("pos_out_valid", 64'(bus.out_valid), 64'd1);
        chk("pos_out_data", 64'(bus.out_data), 64'h50);
        chk("pos_out_tag", 64'(bus.out_tag), 64'd1);

        // Negative values scaled by 1/8 with floor rounding.
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.req_valid = 4'b1000;
            bus.req_data[3*DW +: DW] = nin[i];
            cyc();
            bus.req_valid = '0;
            cyc();
            @(negedge clk);
            chk("neg_out_data", 64'(bus.out_data), 64'(nexp[i]));
            chk("neg_out_tag", 64'(bus.out_tag), 64'd3);
        end

        // Round-robin with everyone valid: 0,1,2,3,0,1 every second cycle.
        cyc();
        bus.req_valid = '1;
        bus.req_data  = 32'h7F_81_3C_C5;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                tags[n] = int'(bus.out_tag); when[n] = c; n++;
            end
        end
        chk("rr_result_count", 64'(n), 64'd6);
        for (int i = 0; i < n; i++) begin
            chk("rr_tag", 64'(tags[i]), 64'(i % 4));
            if (i > 0) chk("rr_spacing", 64'(when[i] - when[i-1]), 64'd2);
        end

        // Requester 2 drops out; after the in-flight result the order is 0,1,3.
        cyc();
        bus.req_valid = 4'b1011;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                tags[n] = int'(bus.out_tag); n++;
            end
        end
        chk("skip_result_count", 64'(n), 64'd6);
        for (int i = 3; i < n; i++) begin
            chk("skip_tag", 64'(tags[i]), 64'((tags[i-1] == 0) ? 1 : (tags[i-1] == 1) ? 3 : 0));
        end

        // Backpressure: held result stays put, no grants.
        cyc();
        bus.out_ready = 1'b0;
        bus.req_valid = '1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1;
        end
        chk("bp_result_seen", 64'(seen), 64'd1);
        hold_d = m_od & 255;
        hold_t = m_ot;
        repeat (5) begin
            cyc();
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_data", 64'(bus.out_data), 64'(hold_d));
            chk("bp_out_tag", 64'(bus.out_tag), 64'(hold_t));
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", 64'(bus.req_ready), 64'(4'b0001 << ((hold_t + 1) % 4)));

        // Reset while computing discards the operand.
        cyc();
        bus.req_valid = 4'b0001;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.req_ready !== 4'b0000) seen = 1;
            else if (c < 9) cyc();
        end
        chk("rstc_accept_seen", 64'(seen), 64'd1);
        cyc();
        rst = 1'b1;
        bus.req_valid = '0;
        cyc();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstc_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rstc_busy", 64'(busy), 64'd0);
            cyc();
        end

`ifdef LRELU_ARB_STATS_EN
        // 310 accepts of requester 0: its counter saturates.
        bus.req_valid = 4'b0001;
        repeat (620) cyc();
        @(negedge clk);
        chk("stat_saturate", 64'(stat_cnt[7:0]), 64'd255);
        chk("stat_others", 64'(stat_cnt[31:8]), 64'd0);
        cyc();
        bus.req_valid = '0;
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst           = ($urandom_range(0, 299) == 0);
            bus.req_valid = N_REQ'($urandom);
            bus.req_data  = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
